incr_arbiter: RTL and testbench
===============================

# incr_arbiter

Round-robin scheduler that shares a single 32-bit incrementer (result = operand + 1, one extra carry bit) among several requesters. Each requester presents an operand with a valid/ready handshake. The block grants one requester at a time, computes the incremented value, and returns it tagged with the requester index on a registered result port with its own valid/ready handshake. It sits between the datapath clients (PC update, loop counters, address stepping) and the shared incrementer.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `WIDTH`, default 32: operand width; the result is `WIDTH+1` bits.
- `IDW`, default `$clog2(N_REQ)`: width of the requester-index tag.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input N_REQ: per-requester operand valid.
- `req_data` input N_REQ*WIDTH: packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready` output N_REQ: grant/accept, at most one bit high; combinational.
- `res_valid` output 1: result available; registered.
- `res_data` output WIDTH+1: incremented operand, including the carry-out MSB; registered.
- `res_id` output IDW: index of the requester that produced `res_data`; registered.
- `res_ready` input 1: downstream consumer accepts the result.

## Operation
- Transfer rules:
  - Request transfer: `req_valid[i] && req_ready[i]` on a rising edge.
  - Result transfer: `res_valid && res_ready` on a rising edge.
- State machine, two states:
  - IDLE: `res_valid`=0. The block may accept a request.
  - HOLD: `res_valid`=1. `res_data` and `res_id` are held stable until the result transfers.
- Transitions:
  - IDLE -> HOLD on a request transfer.
  - HOLD -> IDLE on a result transfer with no new request transfer.
  - HOLD -> HOLD on a request transfer in the same cycle as a result transfer. This applies only when `INCR_ARB_PIPE_EN` is defined.
- Accept condition: the block may accept a request in IDLE. With `INCR_ARB_PIPE_EN` defined, it may also accept in HOLD while `res_ready`=1.
- Grant selection:
  - Search `req_valid` starting at pointer `ptr` and wrap from index N_REQ-1 to 0.
  - The first asserted index gets `req_ready`, provided the accept condition holds.
  - All `req_ready` bits are 0 when the accept condition is false or no `req_valid` bit is set.
- Pointer update: on a request transfer from index i, `ptr` <= (i+1) mod N_REQ. Otherwise `ptr` is unchanged.
- Arithmetic: `res_data` <= {1'b0, operand} + 1, computed at full `WIDTH+1` width. Example: operand 0xFFFF_FFFF gives 0x1_0000_0000. No saturation.
- Requesters must hold `req_data[i]` stable while `req_valid[i]`=1 and the request has not been accepted. Deasserting `req_valid` before acceptance is permitted; that request is simply not granted.
- Reset values:
  - `res_valid`=0, `res_data`=0, `res_id`=0.
  - `ptr`=0, state IDLE.
  - `req_ready`=0 while `rst_n`=0.
- Reset mid-operation: asserting `rst_n` low in HOLD immediately clears `res_valid`, without waiting for a clock edge. The pending result is discarded and never delivered.

## Timing
- Latency: a request accepted at edge t produces `res_valid`=1 with its result after edge t, so the result is visible in cycle t+1.
- `req_ready` depends combinationally on `req_valid`, `ptr`, the state and (with the macro defined) `res_ready`. There are no combinational paths from `req_data` to any output.
- Throughput with `res_ready` held at 1:
  - With `INCR_ARB_PIPE_EN` defined: one result per cycle.
  - Without it: one result every 2 cycles, because HOLD always returns to IDLE before the next accept.
- Backpressure: while `res_valid`=1 and `res_ready`=0, all outputs are frozen and `req_ready` is all 0.
- Deassertion of `rst_n` is synchronised externally. The first accept can occur on the first edge after release.

## Configuration
- Macro `INCR_ARB_PIPE_EN`:
  - Defined: accept is allowed in HOLD when `res_ready`=1, giving back-to-back results.
  - Undefined: accept is allowed only in IDLE.
- Both builds use identical grant order, arithmetic and reset behaviour.

## Test plan
- Single request: `req_valid`=4'b0010 with requester 1 operand 0x0000_0005, `res_ready`=1 -> next cycle `res_valid`=1, `res_data`=0x0_0000_0006, `res_id`=1, and `ptr` becomes 2.
- Wrap: operand 0xFFFF_FFFF -> `res_data`=0x1_0000_0000. Operand 0x0000_0000 -> `res_data`=0x0_0000_0001.
- Fairness: all four requesters valid continuously, `res_ready`=1 -> `res_id` sequence 0,1,2,3,0,1.
- Fairness with a gap: only requesters 0 and 3 valid -> sequence 0,3,0,3.
- Backpressure: result 0x0_0000_000A held with `res_ready`=0 for 3 cycles -> `res_valid`, `res_data` and `res_id` stay constant, and `req_ready`=0 on every cycle.
- Throughput: 8 requests pending, `res_ready`=1 -> 8 results in 8 consecutive cycles with `INCR_ARB_PIPE_EN` defined, or over 16 cycles without it.
- Async reset: drive `rst_n`=0 mid-cycle in HOLD -> `res_valid` drops before the next edge. After release, the first grant goes to the lowest valid index starting from 0.

Source files
------------

// File: rtl/incr_arbiter_if.sv
// Requester/result bundle for incr_arbiter. The master modport is the client side
// (requesters plus result consumer); the slave modport is the arbiter itself.
interface incr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(N_REQ)
);
  // Handshake: an item moves on a rising edge where its valid and ready are both 1.
  // A requester holds its operand while valid and not yet granted; the arbiter
  // holds res_data/res_id while res_valid is high and res_ready is low.
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   res_valid;
  logic [WIDTH:0]         res_data;
  logic [IDW-1:0]         res_id;
  logic                   res_ready;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/incr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit +1 incrementer among N_REQ requesters.
// Define INCR_ARB_PIPE_EN to allow accepting a new request while a result drains.
module incr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic           clk,
  input  logic           rst_n,
  incr_arbiter_if.slave  bus,
  output logic           dbg_hold_o,
  output logic [IDW-1:0] dbg_ptr_o
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [WIDTH:0] res_data_q;
  logic [WIDTH:0] res_data_d;
  logic [IDW-1:0] res_id_q;

  logic [WIDTH-1:0] ops      [N_REQ];
  logic [IDW-1:0]   cand_idx [N_REQ];
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             accept_ok;
  logic             req_fire;
  logic             res_fire;

  // cand_idx[k] is the k-th requester visited when scanning from ptr with wrap.
  for (genvar g = 0; g < N_REQ; g++) begin : g_rot
    logic [IDW:0] sum;
    assign sum         = {1'b0, ptr_q} + (IDW+1)'(g);
    assign cand_idx[g] = (sum >= (IDW+1)'(N_REQ)) ? IDW'(sum - (IDW+1)'(N_REQ))
                                                  : sum[IDW-1:0];
    assign ops[g]      = bus.req_data[g*WIDTH +: WIDTH];
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    // Descending scan so the candidate closest to ptr wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[cand_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

`ifdef INCR_ARB_PIPE_EN
  assign accept_ok = rst_n && ((state_q == IDLE) || bus.res_ready);
`else
  assign accept_ok = rst_n && (state_q == IDLE);
`endif

  assign req_fire = grant_found && accept_ok;
  assign res_fire = (state_q == HOLD) && bus.res_ready;

  always_comb begin
    bus.req_ready = '0;
    if (req_fire) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    res_data_d = {1'b0, ops[grant_idx]} + (WIDTH+1)'(1);
    if (req_fire) begin
      ptr_d = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            state_q    <= HOLD;
            res_data_q <= res_data_d;
            res_id_q   <= grant_idx;
          end
        end
        HOLD: begin
          if (req_fire) begin
            res_data_q <= res_data_d;
            res_id_q   <= grant_idx;
          end else if (res_fire) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.res_valid = (state_q == HOLD);
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign dbg_hold_o    = (state_q == HOLD);
  assign dbg_ptr_o     = ptr_q;

endmodule

// File: tb/tb_incr_arbiter.sv
// Self-checking bench for incr_arbiter: directed cases plus random traffic,
// checked by a round-robin reference model feeding an expected-result queue.
module tb_incr_arbiter;
  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;
`ifdef INCR_ARB_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  localparam int TP_WINDOW = PIPE ? 8 : 16;
  localparam int FAIR_CYC  = PIPE ? 12 : 24;
  localparam int GAP_CYC   = PIPE ? 4 : 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           dbg_hold;
  logic [IDW-1:0] dbg_ptr;

  incr_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  incr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_hold_o (dbg_hold),
    .dbg_ptr_o  (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [IDW+WIDTH:0] exp_q[$];
  int obs_ids[$];
  int results_seen = 0;
  int m_ptr = 0;
  bit m_hold = 1'b0;
  logic [N_REQ-1:0] acc_q = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: grant = first valid index at or after ptr (mod N_REQ).
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      check("ready_in_reset", 64'(bus.req_ready), 64'd0);
    end else begin
      int gi;
      bit accept;
      logic [N_REQ-1:0] exp_ready;
      logic [WIDTH:0] d;
      check("ptr", 64'(dbg_ptr), 64'(m_ptr));
      check("res_valid", 64'(bus.res_valid), 64'(m_hold));
      accept    = !m_hold || (PIPE && bus.res_ready);
      gi        = -1;
      exp_ready = '0;
      if (accept) begin
        for (int k = 0; k < N_REQ; k++) begin
          int idx;
          idx = (m_ptr + k) % N_REQ;
          if (gi < 0 && bus.req_valid[idx]) gi = idx;
        end
      end
      if (gi >= 0) exp_ready[gi] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      if (gi >= 0) begin
        d = WIDTH'(1) + 0;
        d = (WIDTH+1)'(longint'(bus.req_data[gi*WIDTH +: WIDTH]) + 64'd1);
        exp_q.push_back({IDW'(gi), d});
        m_ptr  = (gi + 1) % N_REQ;
        m_hold = 1'b1;
      end else if (m_hold && bus.res_ready) begin
        m_hold = 1'b0;
      end
    end
  end

  always @(negedge rst_n) begin
    m_hold = 1'b0;
    m_ptr  = 0;
    exp_q.delete();
  end

  always @(posedge clk) acc_q <= bus.req_valid & bus.req_ready;

  // Monitor: compare presented result with the queue head, pop on transfer.
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: actual id=%0d data=%0h required=no result", bus.res_id, bus.res_data);
      end else begin
        check("res_id", 64'(bus.res_id), 64'(exp_q[0][IDW+WIDTH -: IDW]));
        check("res_data", 64'(bus.res_data), 64'(exp_q[0][WIDTH:0]));
        if (bus.res_ready) begin
          void'(exp_q.pop_front());
          obs_ids.push_back(int'(bus.res_id));
          results_seen++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic one_shot(input int i, input logic [WIDTH-1:0] v, input logic [WIDTH:0] want);
    @(negedge clk);
    bus.req_data[i*WIDTH +: WIDTH] = v;
    bus.req_valid    = '0;
    bus.req_valid[i] = 1'b1;
    bus.res_ready    = 1'b1;
    @(negedge clk);
    bus.req_valid = '0;
    #3;
    check("direct_valid", 64'(bus.res_valid), 64'd1);
    check("direct_data", 64'(bus.res_data), 64'(want));
    check("direct_id", 64'(bus.res_id), 64'(i));
  endtask

  task automatic run_pattern(input logic [N_REQ-1:0] vmask, input int cycles);
    @(negedge clk);
    obs_ids.delete();
    for (int i = 0; i < N_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = WIDTH'(32'h100 * (i + 1));
    bus.req_valid = vmask;
    bus.res_ready = 1'b1;
    repeat (cycles) @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data", 64'(bus.res_data), 64'd0);
    check("rst_res_id", 64'(bus.res_id), 64'd0);
    check("rst_ptr", 64'(dbg_ptr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    one_shot(1, 32'h0000_0005, 33'h0_0000_0006);
    check("ptr_after_single", 64'(dbg_ptr), 64'd2);
    one_shot(2, 32'hFFFF_FFFF, 33'h1_0000_0000);
    one_shot(3, 32'h0000_0000, 33'h0_0000_0001);
    @(negedge clk);
    check("ptr_before_fair", 64'(dbg_ptr), 64'd0);

    run_pattern(4'b1111, FAIR_CYC);
    check("fair_len", 64'(obs_ids.size() >= 6), 64'd1);
    if (obs_ids.size() >= 6) begin
      int fair_exp [6] = '{0, 1, 2, 3, 0, 1};
      for (int k = 0; k < 6; k++) check("fair_id", 64'(obs_ids[k]), 64'(fair_exp[k]));
    end

    run_pattern(4'b1001, GAP_CYC);
    check("gap_len", 64'(obs_ids.size()), 64'd4);
    if (obs_ids.size() == 4) begin
      int gap_exp [4] = '{0, 3, 0, 3};
      for (int k = 0; k < 4; k++) check("gap_id", 64'(obs_ids[k]), 64'(gap_exp[k]));
    end

    // Backpressure: hold result 0xA while other requesters wait.
    @(negedge clk);
    bus.req_data[2*WIDTH +: WIDTH] = 32'h0000_0009;
    bus.req_valid = 4'b0100;
    bus.res_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bus.req_valid = 4'b1011;
      #3;
      check("bp_valid", 64'(bus.res_valid), 64'd1);
      check("bp_data", 64'(bus.res_data), 64'h0_0000_000A);
      check("bp_id", 64'(bus.res_id), 64'd2);
      check("bp_ready", 64'(bus.req_ready), 64'd0);
    end
    @(negedge clk);
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Throughput with continuous requests.
    begin
      int base;
      for (int i = 0; i < N_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = $urandom();
      bus.req_valid = 4'b1111;
      bus.res_ready = 1'b1;
      base = results_seen;
      repeat (TP_WINDOW) @(negedge clk);
      bus.req_valid = '0;
      #3;
      check("throughput", 64'(results_seen - base), 64'd8);
    end
    repeat (3) @(negedge clk);

    // Async reset while holding a result from requester 2.
    @(negedge clk);
    bus.req_data[2*WIDTH +: WIDTH] = 32'h1234_5678;
    bus.req_valid = 4'b0100;
    bus.res_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = '0;
    #4;
    rst_n = 1'b0;
    #1;
    check("arst_res_valid", 64'(bus.res_valid), 64'd0);
    check("arst_res_data", 64'(bus.res_data), 64'd0);
    check("arst_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    bus.req_valid = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = '0;
    #3;
    check("arst_first_id", 64'(bus.res_id), 64'd1);
    repeat (2) @(negedge clk);

    // Random traffic; operands stay put until granted.
    repeat (400) begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (acc_q[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 99) < 40);
          bus.req_data[i*WIDTH +: WIDTH] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.res_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
    #3;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("results_nonzero", 64'(results_seen > 100), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
